// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, fetch reset defaults and the word-alignment helper.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Primary opcode field values shared with decode.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] addr);
    align_word = {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register carrying {instruction, PC+4, valid}; flush inserts a bubble, hold freezes it.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic [WORD_W-1:0] in_instruction,
  input  logic [WORD_W-1:0] in_pc_plus4,
  output logic [WORD_W-1:0] instruction,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              valid
);

  // Flush outranks hold so a squashed instruction never lingers behind a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction <= NOP_WORD;
      pc_plus4    <= 32'd0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_WORD;
      pc_plus4    <= 32'd0;
      valid       <= 1'b0;
    end else if (hold) begin
      instruction <= instruction;
      pc_plus4    <= pc_plus4;
      valid       <= valid;
    end else begin
      instruction <= in_instruction;
      pc_plus4    <= in_pc_plus4;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (branch > jump > stall > PC+4),
// IF/ID register and a count of instructions accepted into IF/ID.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              JumpEn,
  input  logic [WORD_W-1:0] JumpTarget,
  input  logic              BranchEn,
  input  logic [WORD_W-1:0] BranchTarget,
  output logic [WORD_W-1:0] InstrAddress,
  input  logic [WORD_W-1:0] InstrData,
  output logic [WORD_W-1:0] IFID_Instruction,
  output logic [WORD_W-1:0] IFID_PCPlus4,
  output logic              IFID_Valid,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] FetchCount
);

  logic [WORD_W-1:0] pc_value;
  logic [WORD_W-1:0] pc_plus4;
  logic [WORD_W-1:0] next_pc;
  logic [WORD_W-1:0] fetch_count;
  logic              flush;
  logic              load;

  // Branch belongs to the older instruction, so it beats the jump; any redirect beats stall.
  always_comb begin
    pc_plus4 = pc_value + 32'd4;
    flush    = BranchEn | JumpEn;
    load     = ~flush & ~Stall;
    next_pc  = pc_plus4;
    if (BranchEn) begin
      next_pc = align_word(BranchTarget);
    end else if (JumpEn) begin
      next_pc = align_word(JumpTarget);
    end else if (Stall) begin
      next_pc = pc_value;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Program counter register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_value <= align_word(RESET_PC);
    end else begin
      pc_value <= next_pc;
    end
  end

  // Counts only edges where IF/ID accepts a freshly fetched word.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fetch_count <= 32'd0;
    end else if (load) begin
      fetch_count <= fetch_count + 32'd1;
    end else begin
      fetch_count <= fetch_count;
    end
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id_reg (
    .clk           (Clk),
    .rst           (Reset),
    .flush         (flush),
    .hold          (Stall),
    .in_instruction(InstrData),
    .in_pc_plus4   (pc_plus4),
    .instruction   (IFID_Instruction),
    .pc_plus4      (IFID_PCPlus4),
    .valid         (IFID_Valid)
  );

  assign InstrAddress = align_word(pc_value);
  assign PC           = pc_value;
  assign FetchCount   = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage against a 128-word ROM model.
module tb_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        Stall;
  logic        JumpEn;
  logic [31:0] JumpTarget;
  logic        BranchEn;
  logic [31:0] BranchTarget;
  logic [31:0] InstrAddress;
  logic [31:0] InstrData;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic [31:0] PC;
  logic [31:0] FetchCount;

  logic [31:0] rom [128];

  int pass_count;
  int total_count;

  typedef struct {
    logic        stall;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        branch_en;
    logic [31:0] branch_target;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pcp4;
    logic        exp_valid;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs [17];

  fetch_stage dut (
    .Clk             (Clk),
    .Reset           (Reset),
    .Stall           (Stall),
    .JumpEn          (JumpEn),
    .JumpTarget      (JumpTarget),
    .BranchEn        (BranchEn),
    .BranchTarget    (BranchTarget),
    .InstrAddress    (InstrAddress),
    .InstrData       (InstrData),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
    .IFID_Valid      (IFID_Valid),
    .PC              (PC),
    .FetchCount      (FetchCount)
  );

  assign InstrData = rom[InstrAddress[8:2]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_count++;
    if (act === exp) begin
      pass_count++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic je, input logic [31:0] jt,
                              input logic be, input logic [31:0] bt,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] p4, input logic v, input logic [31:0] cnt);
    vec_t r;
    r.stall = st; r.jump_en = je; r.jump_target = jt;
    r.branch_en = be; r.branch_target = bt;
    r.exp_pc = pc; r.exp_instr = ins; r.exp_pcp4 = p4; r.exp_valid = v; r.exp_count = cnt;
    return r;
  endfunction

  task automatic drive(input logic st, input logic je, input logic [31:0] jt,
                       input logic be, input logic [31:0] bt);
    Stall = st; JumpEn = je; JumpTarget = jt; BranchEn = be; BranchTarget = bt;
  endtask

  initial begin
    int guard;
    pass_count  = 0;
    total_count = 0;

    for (int i = 0; i < 128; i++) rom[i] = 32'hC000_0000 + 32'(i);
    rom[1] = 32'h2008_0000;

    // Expected state after each rising edge, starting from reset release at PC=0.
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h04, 32'hC000_0000, 32'h04, 1'b1, 32'd1);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h2008_0000, 32'h08, 1'b1, 32'd2);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0C, 32'hC000_0002, 32'h0C, 1'b1, 32'd3);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0C, 32'hC000_0002, 32'h0C, 1'b1, 32'd3);
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0C, 32'hC000_0002, 32'h0C, 1'b1, 32'd3);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 32'hC000_0003, 32'h10, 1'b1, 32'd4);
    vecs[6]  = mk(1'b0, 1'b1, 32'h13, 1'b0, 32'h0,  32'h10, 32'h0000_0000, 32'h00, 1'b0, 32'd4);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h14, 32'hC000_0004, 32'h14, 1'b1, 32'd5);
    vecs[8]  = mk(1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 32'h40, 32'h0000_0000, 32'h00, 1'b0, 32'd5);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h44, 32'hC000_0010, 32'h44, 1'b1, 32'd6);
    vecs[10] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hF4, 32'hF4, 32'h0000_0000, 32'h00, 1'b0, 32'd6);
    vecs[11] = mk(1'b0, 1'b1, 32'h04, 1'b0, 32'h0,  32'h04, 32'h0000_0000, 32'h00, 1'b0, 32'd6);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h08, 32'h2008_0000, 32'h08, 1'b1, 32'd7);
    vecs[13] = mk(1'b1, 1'b1, 32'h20, 1'b0, 32'h0,  32'h20, 32'h0000_0000, 32'h00, 1'b0, 32'd7);
    vecs[14] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h24, 32'hC000_0008, 32'h24, 1'b1, 32'd8);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h0000_0000, 32'h00, 1'b0, 32'd8);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h00, 32'hC000_007F, 32'h00, 1'b1, 32'd9);

    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    Reset = 1'b1;
    #2;
    check("reset_pc", PC, 32'h0);
    check("reset_addr", InstrAddress, 32'h0);
    check("reset_instr", IFID_Instruction, 32'h0);
    check("reset_pcp4", IFID_PCPlus4, 32'h0);
    check("reset_valid", {31'd0, IFID_Valid}, 32'h0);
    check("reset_count", FetchCount, 32'h0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].stall, vecs[i].jump_en, vecs[i].jump_target,
            vecs[i].branch_en, vecs[i].branch_target);
      @(posedge Clk);
      #1;
      check($sformatf("v%0d_pc", i), PC, vecs[i].exp_pc);
      check($sformatf("v%0d_addr", i), InstrAddress, vecs[i].exp_pc);
      check($sformatf("v%0d_instr", i), IFID_Instruction, vecs[i].exp_instr);
      check($sformatf("v%0d_pcp4", i), IFID_PCPlus4, vecs[i].exp_pcp4);
      check($sformatf("v%0d_valid", i), {31'd0, IFID_Valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_count", i), FetchCount, vecs[i].exp_count);
      @(negedge Clk);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Free-run up to PC=0x30, then hit reset in the middle of the high phase.
    guard = 0;
    while (PC !== 32'h30 && guard < 40) begin
      @(posedge Clk);
      #1;
      guard++;
    end
    check("reach_pc30", PC, 32'h30);
    check("pc30_valid", {31'd0, IFID_Valid}, 32'h1);
    check("pc30_instr", IFID_Instruction, 32'hC000_000B);
    #2;
    Reset = 1'b1;
    #1;
    check("async_pc", PC, 32'h0);
    check("async_addr", InstrAddress, 32'h0);
    check("async_instr", IFID_Instruction, 32'h0);
    check("async_pcp4", IFID_PCPlus4, 32'h0);
    check("async_valid", {31'd0, IFID_Valid}, 32'h0);
    check("async_count", FetchCount, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("resume_pc", PC, 32'h04);
    check("resume_instr", IFID_Instruction, 32'hC000_0000);
    check("resume_pcp4", IFID_PCPlus4, 32'h04);
    check("resume_valid", {31'd0, IFID_Valid}, 32'h1);
    check("resume_count", FetchCount, 32'd1);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the word-aligned fetch address to the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Applies stall (load-use hold), redirect from jump (ID) and branch (EX), and flush, then hands {instruction, PC+4, valid} to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Stall  input  1  hazard unit: hold PC and IF/ID contents.
- JumpEn  input  1  ID stage resolved j/jal/jr this cycle.
- JumpTarget  input  32  ID-stage jump target.
- BranchEn  input  1  EX stage resolved a taken branch this cycle.
- BranchTarget  input  32  EX-stage branch target.
- InstrAddress  output  32  fetch address to instruction memory (= PC, combinational).
- InstrData  input  32  instruction word returned combinationally for InstrAddress.
- IFID_Instruction  output  32  registered instruction to decode.
- IFID_PCPlus4  output  32  registered PC+4 of that instruction.
- IFID_Valid  output  1  registered: IF/ID holds a real fetched instruction.
- PC  output  32  current PC register (debug/display).
- FetchCount  output  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (async, any time, including mid-stall or mid-redirect): PC=RESET_PC, IFID_Instruction=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, FetchCount=0. All take effect immediately, independent of Clk.
- InstrAddress = {PC[31:2],2'b00}; combinational, zero latency. Memory returns the word in the same cycle.
- PcPlus4 = PC + 4, modulo 2^32; wrap 32'hFFFF_FFFC -> 0 is permitted.
- Next-PC priority, evaluated each rising edge, highest first:
  - BranchEn: PC <= {BranchTarget[31:2],2'b00}.
  - JumpEn: PC <= {JumpTarget[31:2],2'b00}.
  - Stall: PC holds.
  - Otherwise: PC <= PcPlus4.
- Branch beats jump because the branch belongs to the older instruction; the jump in ID is squashed.
- A redirect beats stall because the stalled instruction is being squashed.
- IF/ID update, same priority order:
  - BranchEn or JumpEn (flush): IFID_Instruction <= NOP_WORD, IFID_PCPlus4 <= 0, IFID_Valid <= 0.
  - Stall (no redirect): all IF/ID fields hold.
  - Otherwise: IFID_Instruction <= InstrData, IFID_PCPlus4 <= PcPlus4, IFID_Valid <= 1.
- FetchCount increments by 1 exactly on edges where IF/ID loads a new instruction (case 3 above); wraps at 2^32.
- Latency:
  - Instruction at PC is visible on IFID_* one edge after PC holds it.
  - After a redirect edge, the target instruction appears in IF/ID on the following edge, giving a one-bubble penalty.
- No FSM beyond PC, IF/ID and counter registers. The stage is always fetching; there is no halt.
- Misaligned targets: bits [1:0] are silently forced to 0; no exception.
- Out-of-range addresses are not checked here; the memory indexes its own low word bits.

Decomposition:
- Shared package `mips_pkg`: RESET_PC default, NOP_WORD, WORD_W=32, opcode constants reused by decode.
- One natural sub-module, `if_id_reg`: registered instruction, PC+4 and valid with flush and hold controls, reset to NOP/0/0. It is reused for the stall/flush pattern by later pipeline registers.
- PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset then free run, with InstrData modelled as a 128-word ROM holding addi at word 1: after release, PC sequence 0,4,8,…; on the edge with PC=4, IFID_Instruction becomes 32'h2008_0000 and IFID_PCPlus4 becomes 8. FetchCount=3 after 3 edges.
- Stall held 2 cycles at PC=0x0C: PC stays 0x0C and IF/ID is unchanged for both edges. FetchCount does not advance. On release, PC=0x10 next edge.
- JumpEn=1, JumpTarget=0x04 while PC=0xF4: next edge PC=0x04, IFID_Valid=0, IFID_Instruction=0. The following edge loads word 1 with IFID_Valid=1.
- BranchEn=1 (target 0x40) and JumpEn=1 (target 0x80) together with Stall=1: PC=0x40 and IF/ID is flushed, showing branch over jump over stall.
- Misaligned JumpTarget=0x0000_0013: PC becomes 0x10.
- Reset asserted mid-cycle while PC=0x30 and IFID_Valid=1: outputs clear immediately without a clock edge. After release, fetch resumes at 0x00.
